// File: rtl/matmul_seq_ctrl.sv
// Matrix-multiply sequencer: walks A and B in shared memory, feeds the external
// multiplier over req/ack, accumulates and writes C back in row-major order.
module matmul_seq_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned M        = 2,
  parameter int unsigned K        = 2,
  parameter int unsigned N        = 2,
  parameter int unsigned A_OFFSET = 0,
  parameter int unsigned B_OFFSET = 4,
  parameter int unsigned C_OFFSET = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mult_req,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  input  logic              mult_ack,
  input  logic [DATA_W-1:0] mult_result
);

  localparam int unsigned I_W = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned J_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned K_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    MUL   = 3'd4,
    ACC   = 3'd5,
    WR_C  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic              start_q;
  logic [I_W-1:0]    i_q, i_d;
  logic [J_W-1:0]    j_q, j_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0] acc_sum;
  logic              i_last, j_last, k_last;

  logic              ready_d, mem_rd_en_d, mem_wr_en_d, mult_req_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, mult_a_d, mult_b_d;

  function automatic logic [ADDR_W-1:0] a_addr(input logic [I_W-1:0] row,
                                               input logic [K_W-1:0] col);
    return ADDR_W'(A_OFFSET) + ADDR_W'(row) * ADDR_W'(K) + ADDR_W'(col);
  endfunction

  function automatic logic [ADDR_W-1:0] b_addr(input logic [K_W-1:0] row,
                                               input logic [J_W-1:0] col);
    return ADDR_W'(B_OFFSET) + ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
  endfunction

  function automatic logic [ADDR_W-1:0] c_addr(input logic [I_W-1:0] row,
                                               input logic [J_W-1:0] col);
    return ADDR_W'(C_OFFSET) + ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
  endfunction

  assign acc_sum = acc_q + prod_q;
  assign i_last  = (i_q == I_W'(M - 1));
  assign j_last  = (j_q == J_W'(N - 1));
  assign k_last  = (k_q == K_W'(K - 1));

  // State, indices and all outputs; outputs are computed one state ahead so they are registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      ready     <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
      mult_req  <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      ready     <= ready_d;
      mem_addr  <= mem_addr_d;
      mem_rd_en <= mem_rd_en_d;
      mem_wr_en <= mem_wr_en_d;
      mem_wdata <= mem_wdata_d;
      mult_req  <= mult_req_d;
      mult_a    <= mult_a_d;
      mult_b    <= mult_b_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    ready_d     = ready;
    mem_addr_d  = mem_addr;
    mem_rd_en_d = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_wdata_d = mem_wdata;
    mult_req_d  = 1'b0;
    mult_a_d    = mult_a;
    mult_b_d    = mult_b;

    case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          ready_d     = 1'b0;
          i_d         = '0;
          j_d         = '0;
          k_d         = '0;
          acc_d       = '0;
          state_d     = RD_A;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = a_addr('0, '0);
        end
      end
      RD_A: begin
        state_d     = RD_B;
        mem_rd_en_d = 1'b1;
        mem_addr_d  = b_addr(k_q, j_q);
      end
      RD_B: begin
        mult_a_d = mem_rdata;
        state_d  = CAP_B;
      end
      CAP_B: begin
        mult_b_d   = mem_rdata;
        state_d    = MUL;
        mult_req_d = 1'b1;
      end
      MUL: begin
        if (mult_ack) begin
          prod_d  = mult_result;
          state_d = ACC;
        end else begin
          mult_req_d = 1'b1;
        end
      end
      ACC: begin
        acc_d = acc_sum;
        if (!k_last) begin
          k_d         = k_q + K_W'(1);
          state_d     = RD_A;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = a_addr(i_q, k_q + K_W'(1));
        end else begin
          state_d     = WR_C;
          mem_wr_en_d = 1'b1;
          mem_addr_d  = c_addr(i_q, j_q);
          mem_wdata_d = acc_sum;
        end
      end
      WR_C: begin
        acc_d = '0;
        k_d   = '0;
        if (!j_last) begin
          j_d         = j_q + J_W'(1);
          state_d     = RD_A;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = a_addr(i_q, '0);
        end else if (!i_last) begin
          j_d         = '0;
          i_d         = i_q + I_W'(1);
          state_d     = RD_A;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = a_addr(i_q + I_W'(1), '0);
        end else begin
          j_d     = '0;
          i_d     = '0;
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: memory and multiplier models, a matrix-level
// reference model of the expected access stream, and directed scenarios.
module tb_matmul_seq_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, start8;
  logic          ready, mem_rd_en, mem_wr_en, mult_req, mult_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, mult_a, mult_b, mult_result;

  logic          ready8, mem8_rd_en, mem8_wr_en, mult8_req, mult8_ack;
  logic [AW-1:0] mem8_addr;
  logic [7:0]    mem8_wdata, mem8_rdata, mult8_a, mult8_b, mult8_result;

  int errors = 0;
  int checks = 0;

  matmul_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mult_req(mult_req), .mult_a(mult_a), .mult_b(mult_b),
    .mult_ack(mult_ack), .mult_result(mult_result)
  );

  matmul_seq_ctrl #(
    .DATA_W(8), .ADDR_W(AW), .M(1), .K(2), .N(1),
    .A_OFFSET(0), .B_OFFSET(2), .C_OFFSET(4)
  ) dut8 (
    .clk(clk), .reset(reset), .start(start8), .ready(ready8),
    .mem_addr(mem8_addr), .mem_rd_en(mem8_rd_en), .mem_wr_en(mem8_wr_en),
    .mem_wdata(mem8_wdata), .mem_rdata(mem8_rdata),
    .mult_req(mult8_req), .mult_a(mult8_a), .mult_b(mult8_b),
    .mult_ack(mult8_ack), .mult_result(mult8_result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Memories with one-cycle read latency, plus a bench-side load port
  logic [DW-1:0] mem  [0:15];
  logic [7:0]    mem8 [0:7];
  logic          ld_en = 1'b0;
  logic          ld_sel = 1'b0;
  logic [3:0]    ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (mem_rd_en)  mem_rdata <= mem[mem_addr[3:0]];
    if (mem_wr_en)  mem[mem_addr[3:0]] <= mem_wdata;
    if (mem8_rd_en) mem8_rdata <= mem8[mem8_addr[2:0]];
    if (mem8_wr_en) mem8[mem8_addr[2:0]] <= mem8_wdata;
    if (ld_en && !ld_sel) mem[ld_addr] <= ld_data;
    if (ld_en && ld_sel)  mem8[ld_addr[2:0]] <= ld_data[7:0];
  end

  task automatic mem_load(input logic sel, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_addr = 4'(a); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Multipliers: main one acks after ack_delay wait cycles, 8-bit one acks at once
  int ack_delay = 0;
  int wcnt = 0;
  assign mult_ack     = mult_req && (wcnt == ack_delay);
  assign mult_result  = mult_a * mult_b;
  assign mult8_ack    = mult8_req;
  assign mult8_result = mult8_a * mult8_b;

  always @(posedge clk) begin
    if (!mult_req || mult_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  // Reference model: expected read addresses, operand pairs and C writes
  logic [DW-1:0] ma [2][2];
  logic [DW-1:0] mb [2][2];
  logic [DW-1:0] exp_c [4];
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] op_a_q[$], op_b_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  task automatic model_expect();
    logic [DW-1:0] c;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        c = '0;
        for (int k = 0; k < 2; k++) begin
          rd_q.push_back(AW'(0 + i * 2 + k));
          rd_q.push_back(AW'(4 + k * 2 + j));
          op_a_q.push_back(ma[i][k]);
          op_b_q.push_back(mb[k][j]);
          c = c + ma[i][k] * mb[k][j];
        end
        wr_addr_q.push_back(AW'(8 + i * 2 + j));
        wr_data_q.push_back(c);
        exp_c[i * 2 + j] = c;
      end
    end
  endtask

  // Per-cycle compare of the main DUT against the model
  int            wr_count = 0;
  logic          prev_req = 1'b0;
  logic [DW-1:0] prev_a = '0, prev_b = '0;

  always @(negedge clk) begin
    if (!reset) begin
      rd_q.delete(); op_a_q.delete(); op_b_q.delete();
      wr_addr_q.delete(); wr_data_q.delete();
      prev_req <= 1'b0;
    end else begin
      check("strobe_excl", 64'((int'(mem_rd_en) + int'(mem_wr_en) + int'(mult_req)) > 1), 64'(0));
      if (mem_rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 64'(mem_addr), 64'(1023));
        else                  check("rd_addr", 64'(mem_addr), 64'(rd_q.pop_front()));
      end
      if (mem_wr_en) begin
        wr_count <= wr_count + 1;
        if (wr_addr_q.size() == 0) check("wr_unexpected", 64'(mem_addr), 64'(1023));
        else begin
          check("wr_addr", 64'(mem_addr), 64'(wr_addr_q.pop_front()));
          check("wr_data", 64'(mem_wdata), 64'(wr_data_q.pop_front()));
        end
      end
      if (mult_req && !prev_req) begin
        if (op_a_q.size() == 0) check("op_unexpected", 64'(mult_a), 64'(0));
        else begin
          check("op_a", 64'(mult_a), 64'(op_a_q.pop_front()));
          check("op_b", 64'(mult_b), 64'(op_b_q.pop_front()));
        end
      end
      if (mult_req && prev_req) begin
        check("a_stable", 64'(mult_a), 64'(prev_a));
        check("b_stable", 64'(mult_b), 64'(prev_b));
      end
      prev_req <= mult_req;
      prev_a   <= mult_a;
      prev_b   <= mult_b;
    end
  end

  // Monitor of the 8-bit instance
  int         wr8_count = 0;
  logic [7:0] prod8_q[$];
  always @(negedge clk) begin
    if (reset && mem8_wr_en) begin
      wr8_count <= wr8_count + 1;
      check("c8_addr", 64'(mem8_addr), 64'(4));
    end
    if (reset && mult8_req) prod8_q.push_back(mult8_result);
  end

  task automatic wait_ready(input logic which8, output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if ((which8 ? ready8 : ready) == 1'b1) break;
      if (cyc >= 1000) begin
        check("ready_timeout", 64'(0), 64'(1));
        break;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(ready), 64'(0));
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'(0));
    check({tag, "_wr_en"}, 64'(mem_wr_en), 64'(0));
    check({tag, "_req"},   64'(mult_req), 64'(0));
    check({tag, "_addr"},  64'(mem_addr), 64'(0));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
    check({tag, "_a"},     64'(mult_a), 64'(0));
    check({tag, "_b"},     64'(mult_b), 64'(0));
  endtask

  task automatic check_c(input string tag);
    check({tag, "_c00"}, 64'(mem[8]),  64'(19));
    check({tag, "_c01"}, 64'(mem[9]),  64'(22));
    check({tag, "_c10"}, 64'(mem[10]), 64'(43));
    check({tag, "_c11"}, 64'(mem[11]), 64'(50));
    for (int e = 0; e < 4; e++) check({tag, "_model_c"}, 64'(mem[8 + e]), 64'(exp_c[e]));
    check({tag, "_rd_left"}, 64'(rd_q.size()), 64'(0));
    check({tag, "_wr_left"}, 64'(wr_addr_q.size()), 64'(0));
  endtask

  task automatic idle_hold(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check(tag, 64'({ready, mem_rd_en, mem_wr_en, mult_req}), 64'(4'b1000));
    end
  endtask

  task automatic clear_c();
    for (int a = 8; a < 12; a++) mem_load(1'b0, a, '0);
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check("ready_drop", 64'(ready), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int cyc, wbase;
    reset = 1'b0; start = 1'b1; start8 = 1'b0;
    ma = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}};
    mb = '{'{32'd5, 32'd6}, '{32'd7, 32'd8}};

    // Reset values, memory preload, start held high from reset
    @(negedge clk); #1;
    check_reset_vals("rst");
    for (int a = 0; a < 4; a++) mem_load(1'b0, a, 32'(a + 1));
    for (int a = 4; a < 8; a++) mem_load(1'b0, a, 32'(a + 1));
    clear_c();
    @(posedge clk); #2;
    reset = 1'b1;
    model_expect();
    wbase = wr_count;
    @(posedge clk); #1;
    check("t1_accept_rd", 64'(mem_rd_en), 64'(1));
    wait_ready(1'b0, cyc);
    check("t1_busy", 64'(cyc), 64'(44));
    check_c("t1");
    check("t1_writes", 64'(wr_count - wbase), 64'(4));
    idle_hold("t1_no_retrigger", 10);

    // Toggle start, multiplier acks after 3 wait cycles
    ack_delay = 3;
    clear_c();
    model_expect();
    wbase = wr_count;
    start_pulse();
    wait_ready(1'b0, cyc);
    check("t2_busy", 64'(cyc), 64'(68));
    check_c("t2");
    check("t2_writes", 64'(wr_count - wbase), 64'(4));

    // Start pulsed again during the run is ignored
    ack_delay = 0;
    clear_c();
    model_expect();
    start_pulse();
    fork
      wait_ready(1'b0, cyc);
      begin
        repeat (7) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
      end
    join
    check("t3_busy", 64'(cyc), 64'(44));
    check_c("t3");
    idle_hold("t3_no_restart", 10);

    // Reset during the second MUL of element (0,1)
    clear_c();
    model_expect();
    start_pulse();
    begin
      int n;
      logic pr;
      n = 0; pr = 1'b0;
      for (int c = 0; c < 200 && n < 4; c++) begin
        if (c > 0) begin
          @(posedge clk); #1;
        end
        if (mult_req && !pr) n++;
        pr = mult_req;
      end
      check("t4_reached_mul", 64'(n), 64'(4));
    end
    reset = 1'b0;
    #1;
    check_reset_vals("t4_rst");
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_c00_kept", 64'(mem[8]), 64'(19));
    check("t4_c01_unwr", 64'(mem[9]), 64'(0));
    check("t4_c10_unwr", 64'(mem[10]), 64'(0));
    check("t4_c11_unwr", 64'(mem[11]), 64'(0));
    @(posedge clk); #2;
    reset = 1'b1;
    model_expect();
    wbase = wr_count;
    start_pulse();
    wait_ready(1'b0, cyc);
    check("t4_busy", 64'(cyc), 64'(44));
    check_c("t4");
    check("t4_writes", 64'(wr_count - wbase), 64'(4));

    // 8-bit instance: wrap of the accumulator
    mem_load(1'b1, 0, 32'd20);
    mem_load(1'b1, 1, 32'd10);
    mem_load(1'b1, 2, 32'd10);
    mem_load(1'b1, 3, 32'd10);
    mem_load(1'b1, 4, 32'd0);
    @(negedge clk); start8 = 1'b1;
    @(posedge clk); #1;
    wait_ready(1'b1, cyc);
    check("t5_busy", 64'(cyc), 64'(11));
    check("t5_c", 64'(mem8[4]), 64'(44));
    check("t5_model_c", 64'(mem8[4]), 64'((20 * 10 + 10 * 10) % 256));
    check("t5_writes", 64'(wr8_count), 64'(1));
    check("t5_nprod", 64'(prod8_q.size()), 64'(2));
    if (prod8_q.size() == 2) begin
      check("t5_prod0", 64'(prod8_q[0]), 64'(200));
      check("t5_prod1", 64'(prod8_q[1]), 64'(100));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
